// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the multiply/divide sequencer.
//   op_e     - request opcode (MUL / DIV); any other encoding is illegal.
//   state_e  - sequencer FSM states.
//   W_DEFAULT - default operand width.
package muldiv_pkg;

   localparam int unsigned W_DEFAULT = 32;

   typedef enum logic [1:0] {
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL_RUN,
      DIV_RUN,
      DONE
   } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle of the multiply/divide unit.
//   Request : req_valid, req_ready, op[1:0], a[W-1:0], b[W-1:0]
//   Response: resp_valid, resp_ready, hi[W-1:0], lo[W-1:0], err
//   Status  : busy
//   slave  modport - the unit itself
//   master modport - the requester / result consumer
interface muldiv_sequencer_if #(
   parameter int unsigned W = 32
) ();

   logic         req_valid;
   logic         req_ready;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         err;
   logic         busy;

   modport slave (
      input  req_valid, op, a, b, resp_ready,
      output req_ready, resp_valid, hi, lo, err, busy
   );

   modport master (
      output req_valid, op, a, b, resp_ready,
      input  req_ready, resp_valid, hi, lo, err, busy
   );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div_i - 1: restoring-divide step, 0: shift-add multiply step
//   hi_i     - MUL: upper accumulator half;  DIV: partial remainder
//   lo_i     - MUL: lower half (multiplier bits); DIV: dividend/quotient bits
//   b_i      - multiplier / divisor
//   hi_o/lo_o - next-iteration values of hi_i/lo_i
module muldiv_step #(
   parameter int unsigned W = 32
) (
   input  logic         is_div_i,
   input  logic [W-1:0] hi_i,
   input  logic [W-1:0] lo_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);

   logic [W:0]   sum;   // upper + (b or 0), carry kept in bit W
   logic [W:0]   r_sh;  // remainder shifted left with next dividend bit
   logic [W-1:0] addend;

   assign addend = lo_i[0] ? b_i : '0;
   assign sum    = {1'b0, hi_i} + {1'b0, addend};
   assign r_sh   = {hi_i, lo_i[W-1]};

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (is_div_i) begin
         // When r_sh >= b the difference is below b, so W bits hold it exactly.
         if (r_sh >= {1'b0, b_i}) begin
            hi_o = r_sh[W-1:0] - b_i;
            lo_o = {lo_i[W-2:0], 1'b1};
         end else begin
            hi_o = r_sh[W-1:0];
            lo_o = {lo_i[W-2:0], 1'b0};
         end
      end else begin
         // Shift the (2W+1)-bit {carry, sum, lo} right by one.
         hi_o = sum[W:1];
         lo_o = {sum[0], lo_i[W-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned multiply / restoring divide, one bit per
// cycle, owning the HI/LO result registers.
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset (aborts any operation in flight)
//   bus_io - request (valid/ready, op, a, b) and response (valid/ready, hi, lo,
//            err) channels plus busy status
// Results: MUL -> {hi,lo} = a*b; DIV -> lo = quotient, hi = remainder.
// Divide by zero returns hi=a, lo=all ones, err=1; illegal op returns 0/0, err=1.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   muldiv_sequencer_if.slave  bus_io
);

   localparam int unsigned CNT_W = $clog2(W + 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     acc_hi_q;
   logic [W-1:0]     acc_lo_q;
   logic [W-1:0]     b_q;
   logic [W-1:0]     hi_q;
   logic [W-1:0]     lo_q;
   logic             err_q;
   logic             resp_valid_q;
   logic             req_ready_q;
   logic             busy_q;

   logic [W-1:0]     step_hi;
   logic [W-1:0]     step_lo;

   muldiv_step #(
      .W (W)
   ) u_step (
      .is_div_i (state_q == DIV_RUN),
      .hi_i     (acc_hi_q),
      .lo_i     (acc_lo_q),
      .b_i      (b_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         acc_hi_q     <= '0;
         acc_lo_q     <= '0;
         b_q          <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus_io.req_valid) begin
                  b_q         <= bus_io.b;
                  cnt_q       <= CNT_W'(W - 1);
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus_io.op == OP_MUL) begin
                     acc_hi_q <= '0;
                     acc_lo_q <= bus_io.a;
                     state_q  <= MUL_RUN;
                  end else if (bus_io.op == OP_DIV && bus_io.b != '0) begin
                     acc_hi_q <= '0;
                     acc_lo_q <= bus_io.a;
                     state_q  <= DIV_RUN;
                  end else begin
                     // Error completions skip the datapath entirely.
                     state_q <= DONE;
                     err_q   <= 1'b1;
                     if (bus_io.op == OP_DIV) begin
                        hi_q <= bus_io.a;
                        lo_q <= '1;
                     end else begin
                        hi_q <= '0;
                        lo_q <= '0;
                     end
                  end
               end
            end
            MUL_RUN, DIV_RUN: begin
               acc_hi_q <= step_hi;
               acc_lo_q <= step_lo;
               if (cnt_q == '0) begin
                  // Final iteration: publish the result straight from the step.
                  state_q <= DONE;
                  hi_q    <= step_hi;
                  lo_q    <= step_lo;
                  err_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               // resp_valid rises the cycle after DONE is entered.
               if (resp_valid_q && bus_io.resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  resp_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus_io.req_ready  = req_ready_q;
   assign bus_io.resp_valid = resp_valid_q;
   assign bus_io.hi         = hi_q;
   assign bus_io.lo         = lo_q;
   assign bus_io.err        = err_q;
   assign bus_io.busy       = busy_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle unsigned multiply/divide unit that sits beside the 32-bit ALU and owns the HI/LO result registers.
- Accepts one operation at a time over a valid/ready request channel.
- Runs an iterative shift-add multiply or a restoring divide, one bit per cycle.
- Returns HI/LO over a valid/ready response channel; the ALU stays single-cycle for add/sub ops.

Parameters:
- W, 32: operand width; HI/LO each W bits.
- CNT_W, $clog2(W+1): iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- op  in  2  operation: 2'b10 = MUL, 2'b11 = DIV, others illegal.
- a  in  W  multiplicand / dividend.
- b  in  W  multiplier / divisor.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- hi  out  W  MUL: product[2W-1:W]; DIV: remainder.
- lo  out  W  MUL: product[W-1:0]; DIV: quotient.
- err  out  1  qualifies resp: divide-by-zero or illegal op.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, hi=lo=0, err=0, resp_valid=0, busy=0, counter=0. Reset mid-operation aborts the operation; no response is produced.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch a, b and op.
    - MUL -> MUL_RUN.
    - DIV with b!=0 -> DIV_RUN.
    - DIV with b==0, or illegal op -> DONE.
  - MUL_RUN: 2W-bit accumulator {upper, a}. Each cycle: if acc[0] is set, upper += b (W+1-bit add, carry kept); then shift right 1. After W cycles -> DONE.
  - DIV_RUN: remainder R (W+1 bits) and quotient Q. Each cycle: shift {R,Q} left 1; trial = R - b. If trial is non-negative, R = trial and Q[0]=1. After W cycles -> DONE.
  - DONE: resp_valid=1; hi/lo/err stable. On resp_ready -> IDLE.
- Latency: request accepted at edge N; resp_valid is high from edge N+W+1 for MUL/DIV, and from edge N+1 for div-by-zero or illegal op.
- Handshakes:
  - req_ready is 0 outside IDLE; requests offered then are not consumed.
  - resp_valid holds until resp_ready; hi/lo are not modified while resp_valid=1.
  - The new request can be accepted at the earliest one cycle after the DONE->IDLE edge. There is no same-cycle re-accept.
- hi/lo registers update only on entry to DONE and persist after the response handshake until the next completion.
- Divide by zero: hi=a, lo={W{1'b1}}, err=1.
- Illegal op: hi=lo=0, err=1.
- All other completions: err=0.
- Operands are latched at accept; changes on a/b/op during RUN are ignored.
- Counter counts W-1 down to 0; RUN exits when counter==0 at the edge.

Decomposition:
- Package muldiv_pkg: op_e enum (OP_MUL=2'b10, OP_DIV=2'b11), state_e enum (IDLE, MUL_RUN, DIV_RUN, DONE), localparam W_DEFAULT=32.
- One sub-module: muldiv_step, purely combinational single-iteration logic (one shift-add or one restoring-subtract step) parameterised by W. The sequencer instantiates it once and owns all registers, the counter and the FSM.

Test Plan:
- MUL a=7, b=3 -> resp_valid exactly W+1=33 cycles after accept; hi=0, lo=21, err=0.
- MUL a=5,000,000, b=45,000,000 -> hi=32'h0000CCA2, lo=32'hE5131000 (2.25e14), err=0.
- DIV a=59, b=8 -> lo=7, hi=3, err=0; DIV a=7, b=3 -> lo=2, hi=1.
- DIV a=9, b=0 -> resp_valid 1 cycle after accept; hi=9, lo=32'hFFFFFFFF, err=1. op=2'b01 -> hi=lo=0, err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid, hi, lo and err stay stable; req_ready=0 with req_valid=1 (a=2, b=2, MUL) -> not accepted until the cycle after resp_ready=1, then lo=4.
- Assert rst for one cycle 10 cycles into MUL a=7, b=3 -> next cycle state IDLE, busy=0, resp_valid=0, hi=lo=0. A fresh MUL a=1, b=2 then returns hi=0, lo=2.
